// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU ops straight to write-back and runs one
// blocking req/ack data-memory transaction per load/store, with timeout and misalign flags.
module mem_access #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        validM,
   input  logic        flashM,
   input  logic        we_regM,
   input  logic        mux9M,
   input  logic [31:0] resultM,
   input  logic [31:0] wdataM,
   input  logic [4:0]  rdM,
   input  logic [4:0]  rs1M,
   input  logic [4:0]  rs2M,
   input  logic [1:0]  cmdM,
   input  logic [19:0] imm20M,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        we_regW,
   output logic        mux9W,
   output logic [31:0] resultW,
   output logic [31:0] memW,
   output logic [4:0]  rdW,
   output logic [4:0]  rs1W,
   output logic [4:0]  rs2W,
   output logic [1:0]  cmdW,
   output logic [19:0] imm20W,
   output logic        stall_out,
   output logic        err_timeout,
   output logic        err_misalign,
   input  logic        err_clr
);

   localparam logic IDLE = 1'b0;
   localparam logic BUSY = 1'b1;

   localparam logic [1:0] CMD_LW = 2'b01;
   localparam logic [1:0] CMD_SW = 2'b10;
   localparam logic [7:0] lastCnt = 8'(TIMEOUT_CYC - 1);

   logic        state, stateNxt;
   logic [7:0]  waitCnt, waitCntNxt;
   logic        loadHold, setTimeout, setMisalign;

   logic        holdWe, holdMux9;
   logic [31:0] holdResult, holdWdata;
   logic [4:0]  holdRd, holdRs1, holdRs2;
   logic [1:0]  holdCmd;
   logic [19:0] holdImm20;

   logic        weNxt, mux9Nxt;
   logic [31:0] resultNxt, memNxt;
   logic [4:0]  rdNxt, rs1Nxt, rs2Nxt;
   logic [1:0]  cmdNxt;
   logic [19:0] imm20Nxt;

   assign stall_out  = (state == BUSY);
   assign dmem_req   = (state == BUSY);
   assign dmem_we    = (state == BUSY) && (holdCmd == CMD_SW);
   assign dmem_addr  = holdResult;
   assign dmem_wdata = holdWdata;

   // Every path defaults to a bubble; only accepted ALU ops and acked accesses write back.
   always_comb begin
      stateNxt    = state;
      waitCntNxt  = waitCnt;
      loadHold    = 1'b0;
      setTimeout  = 1'b0;
      setMisalign = 1'b0;
      weNxt       = 1'b0;
      mux9Nxt     = 1'b0;
      resultNxt   = '0;
      memNxt      = '0;
      rdNxt       = '0;
      rs1Nxt      = '0;
      rs2Nxt      = '0;
      cmdNxt      = '0;
      imm20Nxt    = '0;
      if (flashM) begin
         stateNxt   = IDLE;
         waitCntNxt = '0;
      end else if (state == IDLE) begin
         if (validM) begin
            if (cmdM == CMD_LW || cmdM == CMD_SW) begin
               if (resultM[1:0] == 2'b00) begin
                  stateNxt   = BUSY;
                  waitCntNxt = '0;
                  loadHold   = 1'b1;
               end else begin
                  setMisalign = 1'b1;
               end
            end else begin
               weNxt     = we_regM;
               mux9Nxt   = mux9M;
               resultNxt = resultM;
               rdNxt     = rdM;
               rs1Nxt    = rs1M;
               rs2Nxt    = rs2M;
               cmdNxt    = cmdM;
               imm20Nxt  = imm20M;
            end
         end
      end else if (dmem_ack) begin
         stateNxt   = IDLE;
         waitCntNxt = '0;
         weNxt      = (holdCmd == CMD_SW) ? 1'b0 : holdWe;
         mux9Nxt    = holdMux9;
         resultNxt  = holdResult;
         memNxt     = (holdCmd == CMD_LW) ? dmem_rdata : 32'h0;
         rdNxt      = holdRd;
         rs1Nxt     = holdRs1;
         rs2Nxt     = holdRs2;
         cmdNxt     = holdCmd;
         imm20Nxt   = holdImm20;
      end else if (waitCnt == lastCnt) begin
         setTimeout = 1'b1;
         stateNxt   = IDLE;
         waitCntNxt = '0;
      end else begin
         waitCntNxt = waitCnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         waitCnt      <= '0;
         holdWe       <= 1'b0;
         holdMux9     <= 1'b0;
         holdResult   <= '0;
         holdWdata    <= '0;
         holdRd       <= '0;
         holdRs1      <= '0;
         holdRs2      <= '0;
         holdCmd      <= '0;
         holdImm20    <= '0;
         we_regW      <= 1'b0;
         mux9W        <= 1'b0;
         resultW      <= '0;
         memW         <= '0;
         rdW          <= '0;
         rs1W         <= '0;
         rs2W         <= '0;
         cmdW         <= '0;
         imm20W       <= '0;
         err_timeout  <= 1'b0;
         err_misalign <= 1'b0;
      end else begin
         state   <= stateNxt;
         waitCnt <= waitCntNxt;
         if (loadHold) begin
            holdWe     <= we_regM;
            holdMux9   <= mux9M;
            holdResult <= resultM;
            holdWdata  <= wdataM;
            holdRd     <= rdM;
            holdRs1    <= rs1M;
            holdRs2    <= rs2M;
            holdCmd    <= cmdM;
            holdImm20  <= imm20M;
         end
         we_regW <= weNxt;
         mux9W   <= mux9Nxt;
         resultW <= resultNxt;
         memW    <= memNxt;
         rdW     <= rdNxt;
         rs1W    <= rs1Nxt;
         rs2W    <= rs2Nxt;
         cmdW    <= cmdNxt;
         imm20W  <= imm20Nxt;
         // A set event in the same cycle as err_clr wins.
         err_timeout  <= setTimeout  | (err_timeout  & ~err_clr);
         err_misalign <= setMisalign | (err_misalign & ~err_clr);
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized ops against a
// transaction-level model (expected write-back packet, request-cycle count, sticky flags).
module tb_mem_access;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        validM = 1'b0, flashM = 1'b0, we_regM = 1'b0, mux9M = 1'b0;
   logic [31:0] resultM = '0, wdataM = '0;
   logic [4:0]  rdM = '0, rs1M = '0, rs2M = '0;
   logic [1:0]  cmdM = '0;
   logic [19:0] imm20M = '0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        we_regW, mux9W;
   logic [31:0] resultW, memW;
   logic [4:0]  rdW, rs1W, rs2W;
   logic [1:0]  cmdW;
   logic [19:0] imm20W;
   logic        stall_out, err_timeout, err_misalign;
   logic        err_clr = 1'b0;

   int checks = 0;
   int errors = 0;
   logic mdlTo = 1'b0;
   logic mdlMis = 1'b0;

   wire [102:0] wAct = {we_regW, mux9W, resultW, memW, rdW, rs1W, rs2W, cmdW, imm20W};

   mem_access #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .validM(validM), .flashM(flashM), .we_regM(we_regM),
      .mux9M(mux9M), .resultM(resultM), .wdataM(wdataM), .rdM(rdM), .rs1M(rs1M),
      .rs2M(rs2M), .cmdM(cmdM), .imm20M(imm20M), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .we_regW(we_regW), .mux9W(mux9W), .resultW(resultW),
      .memW(memW), .rdW(rdW), .rs1W(rs1W), .rs2W(rs2W), .cmdW(cmdW), .imm20W(imm20W),
      .stall_out(stall_out), .err_timeout(err_timeout), .err_misalign(err_misalign),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [102:0] wpack(input logic we, mux9, input logic [31:0] res, mem,
                                          input logic [4:0] rd, rs1, rs2,
                                          input logic [1:0] cmd, input logic [19:0] imm);
      return {we, mux9, res, mem, rd, rs1, rs2, cmd, imm};
   endfunction

   task automatic set_fields();
      we_regM = 1'($urandom);
      mux9M   = 1'($urandom);
      rdM     = 5'($urandom);
      rs1M    = 5'($urandom);
      rs2M    = 5'($urandom);
      imm20M  = 20'($urandom);
   endtask

   task automatic run_alu(input logic [1:0] cmd, input logic [31:0] res);
      logic [102:0] expW;
      set_fields();
      cmdM = cmd; resultM = res; wdataM = $urandom; validM = 1'b1;
      expW = wpack(we_regM, mux9M, res, 32'h0, rdM, rs1M, rs2M, cmd, imm20M);
      step();
      validM = 1'b0;
      checks++;
      if ({stall_out, dmem_req, wAct} !== {2'b00, expW})
         $display("FAIL alu_wb got stall=%b req=%b W=%h exp stall=0 req=0 W=%h",
                  stall_out, dmem_req, wAct, expW);
      if ({stall_out, dmem_req, wAct} !== {2'b00, expW}) errors++;
      step();
      checks++;
      if (wAct !== '0) begin
         errors++;
         $display("FAIL idle_bubble got W=%h exp 0", wAct);
      end
   endtask

   // d = index of the request cycle on which ack is returned (>= TO means never).
   task automatic run_mem(input logic [1:0] cmd, input logic [31:0] addr, wdata, rdata,
                          input int d);
      logic [102:0] expW;
      int busy, expBusy;
      logic isSt;
      isSt = (cmd == 2'b10);
      set_fields();
      cmdM = cmd; resultM = addr; wdataM = wdata; validM = 1'b1;
      expW = wpack(isSt ? 1'b0 : we_regM, mux9M, addr, isSt ? 32'h0 : rdata,
                   rdM, rs1M, rs2M, cmd, imm20M);
      step();
      // Scramble inputs while busy: they must be ignored.
      validM = 1'b0; set_fields();
      resultM = $urandom; wdataM = $urandom; cmdM = 2'($urandom);
      if (addr[1:0] != 2'b00) begin
         mdlMis = 1'b1;
         checks++;
         if ({dmem_req, stall_out, err_misalign, wAct} !== {3'b001, 103'h0}) begin
            errors++;
            $display("FAIL misalign got req=%b stall=%b mis=%b W=%h exp req=0 stall=0 mis=1 W=0",
                     dmem_req, stall_out, err_misalign, wAct);
         end
         step();
         checks++;
         if (dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL misalign_noreq got req=%b exp 0", dmem_req);
         end
         return;
      end
      busy = 0;
      for (int k = 0; k < int'(TO) + 2 && stall_out === 1'b1; k++) begin
         checks++;
         if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, isSt, addr, wdata}) begin
            errors++;
            $display("FAIL req_fields got req=%b we=%b a=%h wd=%h exp req=1 we=%b a=%h wd=%h",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, isSt, addr, wdata);
         end
         if (k == 0) begin
            checks++;
            if (wAct !== '0) begin
               errors++;
               $display("FAIL accept_bubble got W=%h exp 0", wAct);
            end
         end
         busy++;
         dmem_ack   = (k == d);
         dmem_rdata = (k == d) ? rdata : $urandom;
         step();
         dmem_ack = 1'b0;
      end
      expBusy = (d < int'(TO)) ? d + 1 : int'(TO);
      if (d >= int'(TO)) mdlTo = 1'b1;
      checks++;
      if (busy != expBusy || stall_out !== 1'b0 || dmem_req !== 1'b0) begin
         errors++;
         $display("FAIL busy_len got cycles=%0d stall=%b req=%b exp cycles=%0d stall=0 req=0",
                  busy, stall_out, dmem_req, expBusy);
      end
      if (d >= int'(TO)) expW = '0;
      checks++;
      if ({wAct, err_timeout, err_misalign} !== {expW, mdlTo, mdlMis}) begin
         errors++;
         $display("FAIL mem_wb got W=%h to=%b mis=%b exp W=%h to=%b mis=%b",
                  wAct, err_timeout, err_misalign, expW, mdlTo, mdlMis);
      end
   endtask

   task automatic clear_flags();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      mdlTo = 1'b0; mdlMis = 1'b0;
      checks++;
      if ({err_timeout, err_misalign} !== 2'b00) begin
         errors++;
         $display("FAIL err_clr got to=%b mis=%b exp 00", err_timeout, err_misalign);
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({wAct, dmem_req, dmem_we, dmem_addr, dmem_wdata, stall_out, err_timeout,
           err_misalign} !== '0) begin
         errors++;
         $display("FAIL reset_state got W=%h req=%b we=%b a=%h wd=%h stall=%b to=%b mis=%b exp 0",
                  wAct, dmem_req, dmem_we, dmem_addr, dmem_wdata, stall_out, err_timeout,
                  err_misalign);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_directed();
      set_fields();
      we_regM = 1'b1; rdM = 5'd5; cmdM = 2'b00; resultM = 32'h1234; validM = 1'b1;
      step();
      validM = 1'b0;
      checks++;
      if ({resultW, rdW, we_regW, stall_out} !== {32'h1234, 5'd5, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL alu_1234 got res=%h rd=%0d we=%b stall=%b exp 1234 5 1 0",
                  resultW, rdW, we_regW, stall_out);
      end
      run_alu(2'b11, 32'hCAFE0001);
      run_mem(2'b01, 32'h100, 32'h0, 32'hDEADBEEF, 3);
      run_mem(2'b10, 32'h200, 32'hA5A5A5A5, 32'h0, 0);
      run_mem(2'b01, 32'h102, 32'h0, 32'h0, 0);
      clear_flags();
   endtask

   task automatic test_timeout();
      run_mem(2'b01, 32'h300, 32'h0, 32'h11112222, 100);
      clear_flags();
      run_mem(2'b01, 32'h304, 32'h0, 32'h33334444, int'(TO) - 1);
      // Misalign set and clear in the same cycle: set wins.
      err_clr = 1'b1;
      run_mem(2'b10, 32'h401, 32'h5, 32'h0, 0);
      err_clr = 1'b0;
      clear_flags();
   endtask

   task automatic test_flush();
      set_fields();
      cmdM = 2'b01; resultM = 32'h500; validM = 1'b1;
      step();
      validM = 1'b0;
      for (int k = 0; k < int'(TO) - 1; k++) step();
      // Last wait cycle with ack: flush must beat both ack and timeout.
      dmem_ack = 1'b1; dmem_rdata = 32'h12345678; flashM = 1'b1;
      step();
      dmem_ack = 1'b0; flashM = 1'b0;
      checks++;
      if ({stall_out, dmem_req, wAct, err_timeout} !== {2'b00, 103'h0, mdlTo}) begin
         errors++;
         $display("FAIL flush_busy got stall=%b req=%b W=%h to=%b exp 0 0 0 %b",
                  stall_out, dmem_req, wAct, err_timeout, mdlTo);
      end
      set_fields();
      cmdM = 2'b00; resultM = 32'h77; validM = 1'b1; flashM = 1'b1;
      step();
      validM = 1'b0; flashM = 1'b0;
      checks++;
      if ({stall_out, dmem_req, wAct} !== {2'b00, 103'h0}) begin
         errors++;
         $display("FAIL flush_idle got stall=%b req=%b W=%h exp 0 0 0", stall_out, dmem_req, wAct);
      end
   endtask

   task automatic test_reset_busy();
      run_mem(2'b01, 32'h602, 32'h0, 32'h0, 0);
      set_fields();
      cmdM = 2'b10; resultM = 32'h600; wdataM = 32'h99; validM = 1'b1;
      step();
      validM = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      mdlTo = 1'b0; mdlMis = 1'b0;
      checks++;
      if ({dmem_req, dmem_we, stall_out, wAct, err_timeout, err_misalign} !== '0) begin
         errors++;
         $display("FAIL reset_busy got req=%b we=%b stall=%b W=%h to=%b mis=%b exp 0",
                  dmem_req, dmem_we, stall_out, wAct, err_timeout, err_misalign);
      end
      @(negedge clk);
      rst_n = 1'b1;
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      checks++;
      if ({dmem_req, wAct} !== '0) begin
         errors++;
         $display("FAIL reset_no_wb got req=%b W=%h exp 0", dmem_req, wAct);
      end
   endtask

   task automatic test_random();
      int kind;
      logic [31:0] a;
      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 3));
         a = {$urandom} & 32'hFFFF_FFFC;
         case (kind)
            0: run_alu($urandom_range(0, 1) != 0 ? 2'b11 : 2'b00, $urandom);
            1: run_mem(2'b01, a, $urandom, $urandom, int'($urandom_range(0, 5)));
            2: run_mem(2'b10, a, $urandom, $urandom, int'($urandom_range(0, 5)));
            default: run_mem(2'($urandom_range(1, 2)), a | 32'($urandom_range(1, 3)),
                             $urandom, $urandom, 0);
         endcase
         if ($urandom_range(0, 3) == 0) clear_flags();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_timeout();
      test_flush();
      test_reset_busy();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, range 2..255: cycles BUSY waits for dmem_ack before abort.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 validM  in  1  execute stage presents an instruction.
REQ-005 flashM  in  1  synchronous flush of this stage.
REQ-006 we_regM, mux9M  in  1 each  reg-write enable; write-back select (1 = memory data).
REQ-007 resultM  in  32  ALU result / memory byte address; wdataM  in  32  store data.
REQ-008 rdM, rs1M, rs2M  in  5 each; cmdM  in  2 (00 none, 01 load word, 10 store word, 11 none); imm20M  in  20.
REQ-009 dmem_req, dmem_we  out  1 each; dmem_addr, dmem_wdata  out  32 each; dmem_ack  in  1; dmem_rdata  in  32.
REQ-010 we_regW, mux9W  out  1; resultW, memW  out  32; rdW, rs1W, rs2W  out  5; cmdW  out  2; imm20W  out  20 -- registered feed to write-back stage.
REQ-011 stall_out  out  1  upstream must hold its inputs while high.
REQ-012 err_timeout, err_misalign  out  1 each  sticky flags; err_clr  in  1  clears both.

Function
REQ-013 FSM states IDLE, BUSY; stall_out SHALL equal (state==BUSY), combinational from state only.
REQ-014 Accept = IDLE & validM & !flashM; inputs are ignored in BUSY.
REQ-015 Bubble = all W outputs zero (we_regW=0, cmdW=00).
REQ-016 Accepted non-memory op (cmdM 00/11): W outputs <= input fields, memW <= 0, at the accepting edge (latency 1); state stays IDLE.
REQ-017 Accepted load/store with resultM[1:0]==00: fields latched into hold registers, W <= bubble, state -> BUSY, dmem_req=1 from next cycle.
REQ-018 Accepted load/store with resultM[1:0]!=00: no request, W <= bubble, err_misalign <= 1, state stays IDLE.
REQ-019 In BUSY: dmem_req=1, dmem_addr=held resultM, dmem_we=(held cmd==10), dmem_wdata=held wdataM, all stable until exit.
REQ-020 BUSY with dmem_ack=1: W <= held fields, memW <= dmem_rdata for load, memW <= 0 and we_regW <= 0 for store; state -> IDLE; dmem_req low next cycle.
REQ-021 8-bit wait counter cleared on BUSY entry, +1 per BUSY cycle without ack; ack and counter==TIMEOUT_CYC-1 in same cycle: ack wins.
REQ-022 Counter==TIMEOUT_CYC-1 without ack: err_timeout <= 1, W <= bubble, state -> IDLE.
REQ-023 Idle cycle with no accept: W <= bubble.
REQ-024 flashM=1 (any state): W <= bubble, state -> IDLE, counter cleared, dmem_req low next cycle (memory treats req drop as cancel); flashM overrides ack and timeout.
REQ-025 err_clr=1 clears both flags; a set event in the same cycle wins.

Reset
REQ-026 rst_n low asynchronously: state IDLE, counter 0, all W outputs 0, hold registers 0, dmem_req/dmem_we 0, dmem_addr/dmem_wdata 0, err flags 0; stall_out 0.
REQ-027 Reset asserted mid-BUSY SHALL drop dmem_req immediately, with no write-back of the in-flight op.

Verification
REQ-028 ALU op resultM=0x1234, rdM=5, we_regM=1 -> next edge resultW=0x1234, rdW=5, we_regW=1, stall_out stays 0.
REQ-029 Load addr 0x100, ack 3 cycles after req with rdata 0xDEADBEEF -> stall_out high 4 cycles; memW=0xDEADBEEF, we_regW=1 on the cycle after ack.
REQ-030 Store addr 0x200, wdata 0xA5A5A5A5, immediate ack -> dmem_we=1 for one req cycle, then we_regW=0, cmdW=10.
REQ-031 Load addr 0x102 -> dmem_req never rises, err_misalign=1, W bubble; err_clr -> flag 0.
REQ-032 TIMEOUT_CYC=4, no ack -> req high 4 cycles, err_timeout=1, W bubble, IDLE; repeat with ack on 4th cycle -> normal completion, flag 0.
REQ-033 flashM during BUSY, and rst_n low during BUSY -> req drops, W bubble, state IDLE, no write-back.
